pwm_capture: RTL and testbench

PWM capture/decoder that measures an incoming PWM waveform in `clk1` cycles and reports its period and high time. It is the receive-side counterpart of the `pwm` generator in the KnightRider LED path. It is used to loop back and check generated PWM, or to read external PWM sources. Edges are detected on a synchronized copy of the input, and a complete measurement is published once per input period.

---
 rtl/pwm_capture.sv | 135 +++++++++++++
 tb/tb_pwm_capture.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an asynchronous PWM input in clk1 cycles.
// One measurement is published (valid pulse) per input period, at each rise after the first.
module pwm_capture #(
    parameter int unsigned     WIDTH   = 32,
    parameter longint unsigned TIMEOUT = 1048576
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO    = '0;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             prev_q, prev_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             rise;
    logic             fall;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= CNT_ZERO;
            hi_lat_q    <= CNT_ZERO;
            period_q    <= CNT_ZERO;
            high_time_q <= CNT_ZERO;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            hi_lat_q    <= hi_lat_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        s1_d        = pwm_in;
        s2_d        = s1_q;
        prev_d      = s2_q;
        rise        = s2_q & ~prev_q;
        fall        = ~s2_q & prev_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_lat_d    = hi_lat_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;

        if (!en) begin
            // Disabling drops any partial measurement but keeps the last published one.
            state_d   = ST_IDLE;
            cnt_d     = CNT_ZERO;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_ARM;
            cnt_d   = CNT_ZERO;
        end else begin
            cnt_d = rise ? CNT_ONE : cnt_q + CNT_ONE;
            // An edge in the same cycle always wins over the timeout check.
            if (!rise && !fall && (cnt_q == TIMEOUT_CNT)) begin
                timeout_d = 1'b1;
                locked_d  = 1'b0;
                state_d   = ST_ARM;
                cnt_d     = CNT_ZERO;
            end else begin
                case (state_q)
                    ST_ARM: begin
                        if (rise) state_d = ST_HIGH;
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            hi_lat_d = cnt_q;
                            state_d  = ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            period_d    = cnt_q;
                            high_time_d = hi_lat_q;
                            valid_d     = 1'b1;
                            locked_d    = 1'b1;
                            timeout_d   = 1'b0;
                            state_d     = ST_HIGH;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: every rise the bench drives queues the measurement it expects
// to see published, and every sampled cycle checks valid pulses and held outputs against that.
module tb_pwm_capture;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] per;
        logic [W-1:0] hi;
        logic         gap_ok;
    } exp_t;

    logic         clk1;
    logic         rst;
    logic         en;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         locked;
    logic         timeout;

    exp_t         exp_q[$];
    int           n_cmp;
    int           n_err;
    int           cyc;
    int           n_valid;
    int           last_valid;
    int           first_valid;
    int           rises;
    int           prev_per;
    int           prev_hi;
    int           n0;
    int           c0;
    logic [W-1:0] mdl_p;
    logic [W-1:0] mdl_h;

    pwm_capture #(
        .WIDTH  (W),
        .TIMEOUT(256)
    ) dut (
        .clk1     (clk1),
        .rst      (rst),
        .en       (en),
        .pwm_in   (pwm_in),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .locked   (locked),
        .timeout  (timeout)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the active edge.
    task automatic tick();
        exp_t e;
        @(posedge clk1);
        #1;
        cyc++;
        if (rst !== 1'b1) begin
            if (valid === 1'b1) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("valid_period", period, e.per);
                    check("valid_high_time", high_time, e.hi);
                    if (e.gap_ok) check("valid_spacing", 32'(cyc - last_valid), e.per);
                    mdl_p = e.per;
                    mdl_h = e.hi;
                end
                last_valid = cyc;
            end else begin
                check("hold_period", period, mdl_p);
                check("hold_high_time", high_time, mdl_h);
            end
        end
    endtask

    // Drive a rising edge; the period that it completes is expected to be published.
    task automatic rise_now(input int per, input int hi);
        exp_t e;
        if (rises >= 1) begin
            e.per    = 32'(prev_per);
            e.hi     = 32'(prev_hi);
            e.gap_ok = (rises >= 2);
            exp_q.push_back(e);
        end
        rises++;
        prev_per = per;
        prev_hi  = hi;
        pwm_in   = 1'b1;
    endtask

    task automatic pwm_periods(input int hi, input int per, input int n);
        for (int i = 0; i < n; i++) begin
            rise_now(per, hi);
            repeat (hi) tick();
            pwm_in = 1'b0;
            repeat (per - hi) tick();
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; n_valid = 0;
        last_valid = -1; first_valid = -1; rises = 0;
        prev_per = 0; prev_hi = 0; mdl_p = '0; mdl_h = '0;
        rst = 1'b1; en = 1'b0; pwm_in = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_period", period, 32'd0);
        check("rst_high_time", high_time, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0;
        tick();
        en = 1'b1;
        repeat (3) tick();

        // Basic 100/30: rises at c0+0..400, valids from the second rise, 3 cycles of latency
        n0 = n_valid; c0 = cyc; first_valid = -1;
        pwm_periods(30, 100, 5);
        check("basic_valid_count", 32'(n_valid - n0), 32'd4);
        check("basic_first_valid", 32'(first_valid - c0), 32'd103);
        check("basic_locked", {31'd0, locked}, 32'd1);
        check("basic_timeout", {31'd0, timeout}, 32'd0);

        // Duty extremes: 1/2 then 99/100
        n0 = n_valid;
        pwm_periods(1, 2, 8);
        pwm_periods(99, 100, 3);
        check("duty_valid_count", 32'(n_valid - n0), 32'd11);
        check("duty_period", period, 32'd100);
        check("duty_high_time", high_time, 32'd99);
        check("duty_queue_drained", 32'(exp_q.size()), 32'd0);

        // Timeout: lock on 100/30, then hold high; timeout lands 259 samples after the drive
        pwm_periods(30, 100, 3);
        rise_now(0, 0);
        repeat (258) tick();
        check("to_not_yet", {31'd0, timeout}, 32'd0);
        check("to_locked_before", {31'd0, locked}, 32'd1);
        tick();
        check("to_set", {31'd0, timeout}, 32'd1);
        check("to_locked_cleared", {31'd0, locked}, 32'd0);
        check("to_period_kept", period, 32'd100);
        check("to_high_kept", high_time, 32'd30);
        rises = 0;
        pwm_in = 1'b0;
        repeat (10) tick();
        n0 = n_valid;
        pwm_periods(30, 100, 1);
        check("to_sticky", {31'd0, timeout}, 32'd1);
        check("to_rearm_no_valid", 32'(n_valid - n0), 32'd0);
        pwm_periods(30, 100, 1);
        check("to_cleared", {31'd0, timeout}, 32'd0);
        check("to_relocked", {31'd0, locked}, 32'd1);
        check("to_resume_valid", 32'(n_valid - n0), 32'd1);

        // Enable abort mid-high
        pwm_periods(30, 100, 2);
        rise_now(100, 30);
        repeat (10) tick();
        en = 1'b0;
        rises = 0;
        n0 = n_valid;
        repeat (20) tick();
        pwm_in = 1'b0;
        repeat (70) tick();
        check("dis_no_valid", 32'(n_valid - n0), 32'd0);
        check("dis_locked", {31'd0, locked}, 32'd0);
        check("dis_timeout", {31'd0, timeout}, 32'd0);
        check("dis_period_hold", period, 32'd100);
        check("dis_high_hold", high_time, 32'd30);
        en = 1'b1;
        pwm_periods(30, 100, 1);
        check("reen_one_rise", 32'(n_valid - n0), 32'd0);
        check("reen_unlocked", {31'd0, locked}, 32'd0);
        pwm_periods(30, 100, 1);
        check("reen_two_rises", 32'(n_valid - n0), 32'd1);
        check("reen_locked", {31'd0, locked}, 32'd1);

        // Asynchronous reset while in LOW and locked
        #2 rst = 1'b1;
        mdl_p = '0; mdl_h = '0;
        #1;
        check("arst_period", period, 32'd0);
        check("arst_high_time", high_time, 32'd0);
        check("arst_valid", {31'd0, valid}, 32'd0);
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_timeout", {31'd0, timeout}, 32'd0);
        tick();
        rst = 1'b0;
        rises = 0;
        n0 = n_valid; c0 = cyc; first_valid = -1;
        pwm_periods(30, 100, 1);
        check("arst_one_rise", 32'(n_valid - n0), 32'd0);
        pwm_periods(30, 100, 1);
        check("arst_two_rises", 32'(n_valid - n0), 32'd1);
        check("arst_first_valid", 32'(first_valid - c0), 32'd103);

        // Period change 100/30 -> 50/10 at a rise
        pwm_periods(30, 100, 2);
        n0 = n_valid;
        pwm_periods(10, 50, 5);
        check("chg_valid_count", 32'(n_valid - n0), 32'd5);
        check("chg_period", period, 32'd50);
        check("chg_high_time", high_time, 32'd10);
        check("chg_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
